branch_predict_unit: RTL and testbench

Parametrised successor to the single-cycle branch decision logic, for the pipelined core.
- Fetch side: a direct-mapped table of 2-bit saturating counters gives a combinational taken/not-taken prediction.
- Execute side: resolves B-type branches for any XLEN, updates the table, and reports a registered mispredict/flush one cycle later.
- Also keeps wrapping branch and mispredict statistics counters.

---
 rtl/branch_predict_unit_pkg.sv | 37 +++
 rtl/branch_predict_unit_if.sv | 47 ++++
 rtl/branch_predict_unit_cmp.sv | 17 +
 rtl/branch_predict_unit.sv | 124 ++++++++++++
 tb/tb_branch_predict_unit.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/branch_predict_unit_pkg.sv
// Shared branch-unit definitions: B-type funct3 encodings, the BHT
// counter states and the saturating counter step used by the table.
package branch_predict_unit_pkg;

  // B-type funct3 encodings (010 and 011 are unused by the ISA)
  localparam logic [2:0] OP_B_TYPE_BEQ  = 3'b000;
  localparam logic [2:0] OP_B_TYPE_BNE  = 3'b001;
  localparam logic [2:0] OP_B_TYPE_BLT  = 3'b100;
  localparam logic [2:0] OP_B_TYPE_BGE  = 3'b101;
  localparam logic [2:0] OP_B_TYPE_BLTU = 3'b110;
  localparam logic [2:0] OP_B_TYPE_BGEU = 3'b111;

  // 2-bit saturating counter; the MSB is the taken prediction
  typedef enum logic [1:0] {
    BHT_SNT = 2'b00,
    BHT_WNT = 2'b01,
    BHT_WT  = 2'b10,
    BHT_ST  = 2'b11
  } bht_state_t;

  // True for the six funct3 values that encode a real branch
  function automatic logic is_legal_branch(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

  // One training step of a counter, saturating at both ends
  function automatic logic [1:0] bht_step(input logic [1:0] s, input logic taken);
    logic [1:0] r;
    if (taken) begin
      r = (s == BHT_ST) ? BHT_ST : s + 2'd1;
    end else begin
      r = (s == BHT_SNT) ? BHT_SNT : s - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Pipeline-facing bundle of the branch predict unit: fetch-side lookup,
// execute-side resolve, registered results and statistics.
interface branch_predict_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);

  // fetch side
  logic [XLEN-1:0]  pred_pc;
  logic             pred_taken;

  // execute side
  logic             res_valid;
  logic             b_type;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [XLEN-1:0]  res_pc;
  logic             res_pred_taken;

  // registered resolve results
  logic             branch_taken;
  logic             mispredict;
  logic             illegal_br;

  // statistics
  logic             stat_clear;
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_mispredicts;

  // pipeline side drives lookups and resolves
  modport master (
    output pred_pc, res_valid, b_type, funct3, rs1_data, rs2_data,
           res_pc, res_pred_taken, stat_clear,
    input  pred_taken, branch_taken, mispredict, illegal_br,
           stat_branches, stat_mispredicts
  );

  // predictor side
  modport slave (
    input  pred_pc, res_valid, b_type, funct3, rs1_data, rs2_data,
           res_pc, res_pred_taken, stat_clear,
    output pred_taken, branch_taken, mispredict, illegal_br,
           stat_branches, stat_mispredicts
  );

endinterface

// File: rtl/branch_predict_unit_cmp.sv
// Operand comparator for branch resolution; kept standalone so the ALU
// path can share it.
module branch_cmp #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            eq,
  output logic            lt,
  output logic            ltu
);

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped 2-bit BHT predictor with execute-stage branch resolution,
// one-cycle registered outcome/mispredict reporting and wrapping stats.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_predict_unit_if.slave bus
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [IDX_W-1:0]         pred_idx;
  logic [IDX_W-1:0]         res_idx;
  logic [2*BHT_ENTRIES-1:0] bht_vec;
  logic                     cmp_eq;
  logic                     cmp_lt;
  logic                     cmp_ltu;
  logic                     outcome;
  logic                     legal_f3;
  logic                     rv;
  logic                     illegal_hit;
  logic                     mispred_now;
  logic                     branch_taken_reg;
  logic                     mispredict_reg;
  logic                     illegal_br_reg;
  logic [CNT_W-1:0]         stat_branches_reg;
  logic [CNT_W-1:0]         stat_mispredicts_reg;
  logic                     unused_pc_bits;

  // Word-aligned PCs: the low two bits never select an entry
  assign pred_idx       = bus.pred_pc[IDX_W+1:2];
  assign res_idx        = bus.res_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{bus.pred_pc, bus.res_pc};

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .a   (bus.rs1_data),
    .b   (bus.rs2_data),
    .eq  (cmp_eq),
    .lt  (cmp_lt),
    .ltu (cmp_ltu)
  );

  // Branch condition selected by funct3
  always_comb begin
    outcome = 1'b0;
    case (bus.funct3)
      OP_B_TYPE_BEQ:  outcome = cmp_eq;
      OP_B_TYPE_BNE:  outcome = ~cmp_eq;
      OP_B_TYPE_BLT:  outcome = cmp_lt;
      OP_B_TYPE_BGE:  outcome = ~cmp_lt;
      OP_B_TYPE_BLTU: outcome = cmp_ltu;
      OP_B_TYPE_BGEU: outcome = ~cmp_ltu;
      default:        outcome = 1'b0;
    endcase
  end

  assign legal_f3    = is_legal_branch(bus.funct3);
  assign rv          = bus.res_valid & bus.b_type & legal_f3;
  assign illegal_hit = bus.res_valid & bus.b_type & ~legal_f3;
  assign mispred_now = outcome ^ bus.res_pred_taken;

  // One counter per entry; the resolving branch trains only its own entry.
  // Reads see the pre-update value because the write lands on the edge.
  for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
    logic [1:0] entry_reg;

    // Train the entry addressed by a legal resolving branch
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        entry_reg <= BHT_WNT;
      end else if (rv && (res_idx == IDX_W'(gi))) begin
        entry_reg <= bht_step(entry_reg, outcome);
      end
    end

    assign bht_vec[2*gi +: 2] = entry_reg;
  end

  // Prediction is the counter MSB, no latency
  assign bus.pred_taken = bht_vec[{pred_idx, 1'b1}];

  // Resolve results appear one cycle after the branch; idle cycles read 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_taken_reg <= 1'b0;
      mispredict_reg   <= 1'b0;
      illegal_br_reg   <= 1'b0;
    end else begin
      branch_taken_reg <= rv & outcome;
      mispredict_reg   <= rv & mispred_now;
      illegal_br_reg   <= illegal_hit;
    end
  end

  // Wrapping statistics; a clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_reg    <= '0;
      stat_mispredicts_reg <= '0;
    end else if (bus.stat_clear) begin
      stat_branches_reg    <= '0;
      stat_mispredicts_reg <= '0;
    end else begin
      if (rv) begin
        stat_branches_reg <= stat_branches_reg + CNT_W'(1);
      end
      if (rv && mispred_now) begin
        stat_mispredicts_reg <= stat_mispredicts_reg + CNT_W'(1);
      end
    end
  end

  assign bus.branch_taken     = branch_taken_reg;
  assign bus.mispredict       = mispredict_reg;
  assign bus.illegal_br       = illegal_br_reg;
  assign bus.stat_branches    = stat_branches_reg;
  assign bus.stat_mispredicts = stat_mispredicts_reg;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit (XLEN=32, 64 entries, 4-bit stats).
module tb_branch_predict_unit;
  import branch_predict_unit_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  branch_predict_unit_if #(.XLEN(32), .CNT_W(4)) bus ();

  branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(64), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts, reports every transaction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  // Present one resolve for a cycle; returns #1 after the capturing edge
  task automatic do_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic pt, input logic sc);
    bus.res_valid      = 1'b1;
    bus.b_type         = 1'b1;
    bus.funct3         = f3;
    bus.rs1_data       = a;
    bus.rs2_data       = b;
    bus.res_pc         = pc;
    bus.res_pred_taken = pt;
    bus.stat_clear     = sc;
    @(posedge clk);
    #1;
    bus.res_valid  = 1'b0;
    bus.b_type     = 1'b0;
    bus.stat_clear = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic bt, input logic mp, input logic ill);
    chk({tag, ".taken"}, 64'(bus.branch_taken), 64'(bt));
    chk({tag, ".mispred"}, 64'(bus.mispredict), 64'(mp));
    chk({tag, ".illegal"}, 64'(bus.illegal_br), 64'(ill));
  endtask

  task automatic chk_stats(input string tag, input int br, input int mp);
    chk({tag, ".branches"}, 64'(bus.stat_branches), 64'(br));
    chk({tag, ".mispreds"}, 64'(bus.stat_mispredicts), 64'(mp));
  endtask

  task automatic chk_pred(input string tag, input logic [31:0] pc, input logic exp);
    bus.pred_pc = pc;
    #1;
    chk(tag, 64'(bus.pred_taken), 64'(exp));
  endtask

  initial begin
    checks             = 0;
    errors             = 0;
    rst_n              = 1'b0;
    bus.pred_pc        = '0;
    bus.res_valid      = 1'b0;
    bus.b_type         = 1'b0;
    bus.funct3         = '0;
    bus.rs1_data       = '0;
    bus.rs2_data       = '0;
    bus.res_pc         = '0;
    bus.res_pred_taken = 1'b0;
    bus.stat_clear     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_res("reset", 1'b0, 1'b0, 1'b0);
    chk_stats("reset", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: first BEQ trains entry 0 from 01 to 10
    chk_pred("t1.pred_before", 32'h100, 1'b0);
    do_res(OP_B_TYPE_BEQ, 32'd5, 32'd5, 32'h100, 1'b0, 1'b0);
    chk_res("t1.beq", 1'b1, 1'b1, 1'b0);
    chk_pred("t1.pred_after", 32'h100, 1'b1);
    @(posedge clk);
    #1;
    chk_res("t1.idle", 1'b0, 1'b0, 1'b0);
    chk_stats("t1", 1, 1);

    // 2: saturate entry 16 at 11, then step back down to 01
    for (int i = 0; i < 4; i++) begin
      do_res(OP_B_TYPE_BLT, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1, 1'b0);
      chk_res($sformatf("t2.blt_taken%0d", i), 1'b1, 1'b0, 1'b0);
    end
    chk_pred("t2.pred_sat", 32'h40, 1'b1);
    do_res(OP_B_TYPE_BLT, 32'd1, 32'hFFFF_FFFF, 32'h40, 1'b1, 1'b0);
    chk_res("t2.blt_nt0", 1'b0, 1'b1, 1'b0);
    chk_pred("t2.pred_10", 32'h40, 1'b1);
    do_res(OP_B_TYPE_BLT, 32'd1, 32'hFFFF_FFFF, 32'h40, 1'b1, 1'b0);
    chk_res("t2.blt_nt1", 1'b0, 1'b1, 1'b0);
    chk_pred("t2.pred_01", 32'h40, 1'b0);
    chk_stats("t2", 7, 3);

    // 3: signed vs unsigned on 0x80000000 vs 1 (entry 2)
    do_res(OP_B_TYPE_BLT, 32'h8000_0000, 32'd1, 32'h208, 1'b0, 1'b0);
    chk_res("t3.blt", 1'b1, 1'b1, 1'b0);
    do_res(OP_B_TYPE_BLTU, 32'h8000_0000, 32'd1, 32'h208, 1'b0, 1'b0);
    chk_res("t3.bltu", 1'b0, 1'b0, 1'b0);
    do_res(OP_B_TYPE_BGEU, 32'h8000_0000, 32'd1, 32'h208, 1'b1, 1'b0);
    chk_res("t3.bgeu", 1'b1, 1'b0, 1'b0);
    chk_pred("t3.pred", 32'h208, 1'b1);
    chk_stats("t3", 10, 4);

    // 4: illegal funct3 pulses once, trains nothing
    do_res(3'b010, 32'd1, 32'd1, 32'h208, 1'b0, 1'b0);
    chk_res("t4.illegal", 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk_res("t4.after", 1'b0, 1'b0, 1'b0);
    chk_stats("t4", 10, 4);
    chk_pred("t4.pred", 32'h208, 1'b1);

    // 5: read-during-write on entry 1, then aliased update
    bus.pred_pc        = 32'h104;
    bus.res_valid      = 1'b1;
    bus.b_type         = 1'b1;
    bus.funct3         = OP_B_TYPE_BEQ;
    bus.rs1_data       = 32'd9;
    bus.rs2_data       = 32'd9;
    bus.res_pc         = 32'h104;
    bus.res_pred_taken = 1'b0;
    #1;
    chk("t5.pred_rdw_old", 64'(bus.pred_taken), 64'(1'b0));
    @(posedge clk);
    #1;
    bus.res_valid = 1'b0;
    bus.b_type    = 1'b0;
    chk_res("t5.beq", 1'b1, 1'b1, 1'b0);
    chk_pred("t5.pred_new", 32'h104, 1'b1);
    do_res(OP_B_TYPE_BEQ, 32'd3, 32'd3, 32'h104 + 32'd256, 1'b1, 1'b0);
    chk_res("t5.alias", 1'b1, 1'b0, 1'b0);
    do_res(OP_B_TYPE_BNE, 32'd3, 32'd3, 32'h104, 1'b1, 1'b0);
    chk_res("t5.bne", 1'b0, 1'b1, 1'b0);
    chk_pred("t5.pred_alias", 32'h104, 1'b1);
    chk_stats("t5", 13, 6);

    // 6: clear, 4-bit wrap, clear beating an increment
    bus.stat_clear = 1'b1;
    @(posedge clk);
    #1;
    bus.stat_clear = 1'b0;
    chk_stats("t6.clear", 0, 0);
    for (int i = 0; i < 17; i++) begin
      do_res(OP_B_TYPE_BEQ, 32'd7, 32'd7, 32'h10, 1'b1, 1'b0);
    end
    chk_stats("t6.wrap", 1, 0);
    do_res(OP_B_TYPE_BEQ, 32'd7, 32'd7, 32'h10, 1'b0, 1'b1);
    chk_res("t6.clr_rv", 1'b1, 1'b1, 1'b0);
    chk_stats("t6.clr_rv", 0, 0);

    // 6: reset mid-stream with a resolve in flight
    do_res(OP_B_TYPE_BEQ, 32'd1, 32'd1, 32'h104, 1'b0, 1'b0);
    chk_res("t6.pre_rst", 1'b1, 1'b1, 1'b0);
    bus.res_valid = 1'b1;
    bus.b_type    = 1'b1;
    rst_n         = 1'b0;
    #1;
    chk_res("t6.in_rst", 1'b0, 1'b0, 1'b0);
    chk_stats("t6.in_rst", 0, 0);
    chk_pred("t6.pred_rst", 32'h104, 1'b0);
    @(posedge clk);
    #1;
    bus.res_valid = 1'b0;
    bus.b_type    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_res("t6.post_rst", 1'b0, 1'b0, 1'b0);
    chk_stats("t6.post_rst", 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
